// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller: sizes, FSM states,
// and the fixed-priority encoder used for winner selection.
package intr_pkg;

    localparam int N_IRQ_DEF = 6;
    localparam int CODE_W    = 3;
    localparam int ENC_W     = 1 << CODE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [ENC_W-1:0] vec);
        prio_enc = '0;
        for (int i = ENC_W - 1; i >= 0; i--) begin
            if (vec[i]) prio_enc = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/intr_debounce.sv
// One interrupt line: two-flop synchronizer, then a filter that accepts a new
// level only after it has been stable for DB_CYCLES cycles. Emits a rise pulse.
module intr_debounce
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized value agrees with the filter restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) level_d = sync2_q;
            else                                cnt_d   = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-line debounce, pending latch, software mask and a
// single-outstanding request/ack/eret handshake toward the CPU.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_IRQ     = N_IRQ_DEF,
    parameter int DB_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_IRQ-1:0]  intr_in,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    output logic [N_IRQ-1:0]  mask_q,
    output logic [N_IRQ-1:0]  pending_q,
    output logic [N_IRQ-1:0]  in_service_q,
    output logic              irq,
    output logic [CODE_W-1:0] irq_code,
    input  logic              ack,
    input  logic              eret
);

    logic [N_IRQ-1:0]  level, rise, set;
    logic [N_IRQ-1:0]  mask_d, pending_d, in_service_d;
    logic [N_IRQ-1:0]  req, cur, clr;
    logic [ENC_W-1:0]  req_ext;
    logic              irq_q, irq_d;
    logic [CODE_W-1:0] code_q, code_d;
    state_e            state_q, state_d;

    generate
        for (genvar g = 0; g < N_IRQ; g++) begin : g_line
            intr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clock   (clock),
                .reset_n (reset_n),
                .raw     (intr_in[g]),
                .level   (level[g]),
                .rise    (rise[g])
            );
        end
    endgenerate

    // A rise pulse is only ever produced alongside a high filtered level.
    assign set = rise & level;

    always_comb begin
        req                 = pending_q & mask_q;
        req_ext             = '0;
        req_ext[N_IRQ-1:0]  = req;
        cur                 = N_IRQ'(1) << code_q;
        state_d             = state_q;
        irq_d               = irq_q;
        code_d              = code_q;
        clr                 = '0;
        in_service_d        = in_service_q;
        mask_d              = mask_we ? mask_wdata : mask_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = REQ;
                    irq_d   = 1'b1;
                    code_d  = prio_enc(req_ext);
                end
            end
            REQ: begin
                // Code stays frozen; a masked-away request is withdrawn, not cleared.
                if (ack) begin
                    state_d      = SVC;
                    irq_d        = 1'b0;
                    clr          = cur;
                    in_service_d = cur;
                end else if (!(|(req & cur))) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end
            SVC: begin
                if (eret) begin
                    state_d      = IDLE;
                    in_service_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // New edge wins over the ack clear on the same bit.
        pending_d = (pending_q & ~clr) | set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_q        <= 1'b0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_q        <= irq_d;
            code_q       <= code_d;
        end
    end

    assign irq      = irq_q;
    assign irq_code = code_q;

endmodule
